chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract unit. Processes CHUNK bits per clock and keeps the
//  inter-chunk carry in a register. Replaces wide combinational ripple chains of full adders
//  in the multiplier datapath, e.g. partial-product accumulation and final carry resolution.
//  Valid/ready handshake on both input and output.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=1)
//  CHUNK  4   bits added per cycle; WIDTH % CHUNK != 0 -> elaboration error; NCHUNK = WIDTH/CHUNK
// PORTS
//  Clk        in   1      single clock, rising edge
//  Rst_n      in   1      asynchronous, active-low reset
//  In_Valid   in   1      operands valid
//  In_Ready   out  1      unit can accept operands
//  In1        in   WIDTH  operand A
//  In2        in   WIDTH  operand B
//  Carry_In   in   1      add: carry-in; sub: borrow-in
//  Sub        in   1      0: A+B+Carry_In; 1: A-B-Carry_In
//  Out_Valid  out  1      result valid
//  Out_Ready  in   1      consumer accepts result
//  Sum        out  WIDTH  result, registered
//  Carry      out  1      carry out of MSB (sub: 1 = no borrow)
//  Overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async, Rst_n=0): state=IDLE, Out_Valid=0, Sum=0, Carry=0, Overflow=0,
//    chunk counter=0, carry reg=0. In_Ready = (state==IDLE), so In_Ready=1 during reset.
//  - FSM: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: In_Ready=1.
//    In_Valid=1 at edge E0: capture In1 as A and (Sub ? ~In2 : In2) as B.
//    carry reg <= Sub ? ~Carry_In : Carry_In. counter <= 0. Go to RUN.
//  - RUN: In_Ready=0. Each edge adds chunk k = bits [k*CHUNK +: CHUNK] of A, B and the carry reg,
//    writes the chunk into the internal result, updates the carry reg, and increments k.
//    At the edge processing k=NCHUNK-1: load Sum, Carry and Overflow; go to DONE.
//  - Latency: Out_Valid=1 after edge E0+NCHUNK. Initiation interval >= NCHUNK+2 cycles.
//  - DONE: Out_Valid=1; Sum/Carry/Overflow held stable. On an edge with Out_Ready=1: Out_Valid<=0, go to IDLE.
//    In_Ready=0 in DONE. No overlap of operations.
//  - Sum/Carry/Overflow hold their last result through IDLE until the next completion.
//  - In1/In2/Sub/Carry_In changes after capture are ignored. In_Valid outside IDLE is ignored.
//  - CHUNK==WIDTH: RUN lasts exactly 1 cycle; Out_Valid=1 after E0+1.
//  - All arithmetic is modulo 2^WIDTH; no saturation.
//  - Rst_n low mid-RUN/DONE: operation aborted immediately, no output produced.
//    After release, the unit is idle and the next operation is exact.
// TESTING  (WIDTH=16, CHUNK=4 unless stated)
//  1. 0x1234+0x0FFF, Cin=0, Sub=0 -> Sum=0x2233, Carry=0, Overflow=0;
//     Out_Valid rises exactly 4 edges after the handshake edge.
//  2. 0xFFFF+0x0001, Cin=1 -> Sum=0x0001, Carry=1, Overflow=0 (carry crosses all chunks).
//     0x7FFF+0x0001 -> Sum=0x8000, Carry=0, Overflow=1.
//  3. Sub: 0x0005-0x0007, Cin=0 -> 0xFFFE, Carry=0, Ovf=0.
//     0x8000-0x0001 -> 0x7FFF, Carry=1, Ovf=1.
//     0x0010-0x0010, Cin=1 -> 0xFFFF, Carry=0.
//  4. Hold Out_Ready=0 for 5 cycles and drive In_Valid=1 throughout
//     -> Out_Valid/Sum stable, In_Ready=0, no capture; new op accepted only after IDLE is re-entered.
//  5. Rst_n=0 after 2 RUN cycles -> Out_Valid=0 and Sum=0 immediately, In_Ready=1;
//     after release, 0x00FF+0x0001 -> 0x0100.
//  6. WIDTH=8, CHUNK=8: 0x80+0x80 -> Sum=0x00, Carry=1, Overflow=1, Out_Valid after E0+1;
//     back-to-back ops with Out_Ready=1 are spaced 3 cycles apart.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle WIDTH-bit add/subtract unit. Each RUN cycle adds CHUNK bits of the
//   captured operands and keeps the carry between chunks in a register. This replaces
//   a wide combinational ripple chain.
//
//   States:
//     state | meaning
//     IDLE  | ready for operands, last result held on outputs
//     RUN   | adding one chunk per clock, LSB chunk first
//     DONE  | result valid, waiting for Out_Ready
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   In_Valid/In_Ready   operand handshake; In_Ready is high only in IDLE
//   In1, In2            operands A and B (WIDTH bits)
//   Carry_In            carry-in for add, borrow-in for subtract
//   Sub                 0: A+B+Carry_In, 1: A-B-Carry_In
//   Out_Valid/Out_Ready result handshake
//   Sum                 registered result, modulo 2^WIDTH
//   Carry               carry out of the MSB (for subtract, 1 means no borrow)
//   Overflow            signed overflow: carry into MSB xor carry out of MSB
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Carry_In,
  input  logic             Sub,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   chunk_add;
  logic             msb_cin;
  logic [WIDTH-1:0] chunk_ext;
  logic [WIDTH-1:0] res_next;

  // Operands shift right each cycle so the current chunk is always in the low bits;
  // the result fills in from the top, ending fully aligned after the last chunk.
  assign chunk_add = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  // Carry into the chunk's top bit; only meaningful on the last chunk (the word MSB).
  assign msb_cin = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ chunk_add[CHUNK-1];

  always_comb begin
    chunk_ext = '0;
    chunk_ext[WIDTH-1 -: CHUNK] = chunk_add[CHUNK-1:0];
    res_next = (res_q >> CHUNK) | chunk_ext;
  end

  assign In_Ready = (state == IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      Out_Valid <= 1'b0;
      Sum       <= '0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            // Subtract as A + ~B + ~borrow_in
            a_sh    <= In1;
            b_sh    <= Sub ? ~In2 : In2;
            carry_q <= Sub ? ~Carry_In : Carry_In;
            res_q   <= '0;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          res_q   <= res_next;
          carry_q <= chunk_add[CHUNK];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum       <= res_next;
            Carry     <= chunk_add[CHUNK];
            Overflow  <= chunk_add[CHUNK] ^ msb_cin;
            Out_Valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          Out_Valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
module tb_chunked_serial_adder;

  logic clk;
  logic rst_n;

  // WIDTH=16, CHUNK=4 instance
  logic        iv16, ir16, cin16, sub16, ov16, or16, c16, ovf16;
  logic [15:0] a16, b16, s16;

  // WIDTH=8, CHUNK=8 instance
  logic        iv8, ir8, cin8, sub8, ov8, or8, c8, ovf8;
  logic [7:0]  a8, b8, s8;

  int checks = 0;
  int errors = 0;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .Clk(clk), .Rst_n(rst_n),
    .In_Valid(iv16), .In_Ready(ir16), .In1(a16), .In2(b16),
    .Carry_In(cin16), .Sub(sub16),
    .Out_Valid(ov16), .Out_Ready(or16),
    .Sum(s16), .Carry(c16), .Overflow(ovf16)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .Clk(clk), .Rst_n(rst_n),
    .In_Valid(iv8), .In_Ready(ir8), .In1(a8), .In2(b8),
    .Carry_In(cin8), .Sub(sub8),
    .Out_Valid(ov8), .Out_Ready(or8),
    .Sum(s8), .Carry(c8), .Overflow(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation into dut16 and waits (bounded) for Out_Valid.
  // Leaves the result pending in DONE; release16 consumes it.
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, output int lat);
    @(negedge clk);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; or16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release16;
    @(negedge clk);
    or16 = 1'b1;
    @(posedge clk);
    #1;
    or16 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || s16 !== 16'h0000 || c16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: ir=%b ov=%b sum=%h c=%b ovf=%b, want ir=1 ov=0 sum=0000 c=0 ovf=0",
               ir16, ov16, s16, c16, ovf16);
    end
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h00) begin
      errors++;
      $display("FAIL reset8: ir=%b ov=%b sum=%h, want ir=1 ov=0 sum=00", ir8, ov8, s8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic;
    int lat;
    run_op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d edges, want 4", lat);
    end
    checks++;
    if (s16 !== 16'h2233 || c16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL add_1234_0fff: sum=%h c=%b ovf=%b, want 2233 0 0", s16, c16, ovf16);
    end
    checks++;
    if (ir16 !== 1'b0) begin
      errors++;
      $display("FAIL done_in_ready: got %b, want 0", ir16);
    end
    release16();
    checks++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1 || s16 !== 16'h2233) begin
      errors++;
      $display("FAIL after_release: ov=%b ir=%b sum=%h, want 0 1 2233", ov16, ir16, s16);
    end
  endtask

  task automatic test_carry_chain;
    int lat;
    run_op16(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 4 || s16 !== 16'h0001 || c16 !== 1'b1 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL add_ffff_0001_cin: lat=%0d sum=%h c=%b ovf=%b, want 4 0001 1 0", lat, s16, c16, ovf16);
    end
    release16();
    run_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (s16 !== 16'h8000 || c16 !== 1'b0 || ovf16 !== 1'b1) begin
      errors++;
      $display("FAIL add_7fff_0001: sum=%h c=%b ovf=%b, want 8000 0 1", s16, c16, ovf16);
    end
    release16();
  endtask

  task automatic test_sub;
    int lat;
    run_op16(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    checks++;
    if (s16 !== 16'hFFFE || c16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL sub_5_7: sum=%h c=%b ovf=%b, want fffe 0 0", s16, c16, ovf16);
    end
    release16();
    run_op16(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if (s16 !== 16'h7FFF || c16 !== 1'b1 || ovf16 !== 1'b1) begin
      errors++;
      $display("FAIL sub_8000_1: sum=%h c=%b ovf=%b, want 7fff 1 1", s16, c16, ovf16);
    end
    release16();
    run_op16(16'h0010, 16'h0010, 1'b1, 1'b1, lat);
    checks++;
    if (s16 !== 16'hFFFF || c16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL sub_10_10_bin: sum=%h c=%b ovf=%b, want ffff 0 0", s16, c16, ovf16);
    end
    release16();
  endtask

  task automatic test_backpressure;
    int lat;
    run_op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    @(negedge clk);
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ov16 !== 1'b1 || s16 !== 16'h2233 || ir16 !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: ov=%b sum=%h ir=%b, want 1 2233 0", i, ov16, s16, ir16);
      end
    end
    @(negedge clk);
    or16 = 1'b1;
    @(posedge clk);
    #1;
    or16 = 1'b0;
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || s16 !== 16'h2233) begin
      errors++;
      $display("FAIL hold_release: ir=%b ov=%b sum=%h, want 1 0 2233", ir16, ov16, s16);
    end
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    checks++;
    if (ir16 !== 1'b0) begin
      errors++;
      $display("FAIL hold_recapture: ir=%b, want 0", ir16);
    end
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || s16 !== 16'h0002 || c16 !== 1'b0) begin
      errors++;
      $display("FAIL hold_next_op: lat=%0d sum=%h c=%b, want 4 0002 0", lat, s16, c16);
    end
    release16();
  endtask

  task automatic test_reset_abort;
    int lat;
    run_op16(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    release16();
    @(negedge clk);
    a16 = 16'h4444; b16 = 16'h1111; iv16 = 1'b1;
    @(posedge clk);
    #1;
    iv16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov16 !== 1'b0 || s16 !== 16'h0000 || ir16 !== 1'b1 || c16 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: ov=%b sum=%h ir=%b c=%b, want 0 0000 1 0", ov16, s16, ir16, c16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op16(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || s16 !== 16'h0100 || c16 !== 1'b0 || ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: lat=%0d sum=%h c=%b ovf=%b, want 4 0100 0 0", lat, s16, c16, ovf16);
    end
    release16();
  endtask

  task automatic test_back_to_back;
    int first_idx;
    int second_idx;
    logic [7:0] first_sum;
    logic first_c, first_ovf;
    first_idx = -1;
    second_idx = -1;
    first_sum = 8'hAA;
    first_c = 1'b0;
    first_ovf = 1'b0;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        a8 = 8'h05; b8 = 8'h03; sub8 = 1'b1;
      end
      if (ov8 === 1'b1) begin
        if (first_idx < 0) begin
          first_idx = i;
          first_sum = s8;
          first_c = c8;
          first_ovf = ovf8;
        end else if (second_idx < 0) begin
          second_idx = i;
          checks++;
          if (s8 !== 8'h02 || c8 !== 1'b1 || ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_second_op: sum=%h c=%b ovf=%b, want 02 1 0", s8, c8, ovf8);
          end
        end
      end
    end
    iv8 = 1'b0;
    checks++;
    if (first_idx !== 1) begin
      errors++;
      $display("FAIL w8_latency: out_valid at edge %0d, want 1", first_idx);
    end
    checks++;
    if (first_sum !== 8'h00 || first_c !== 1'b1 || first_ovf !== 1'b1) begin
      errors++;
      $display("FAIL w8_80_80: sum=%h c=%b ovf=%b, want 00 1 1", first_sum, first_c, first_ovf);
    end
    checks++;
    if (second_idx - first_idx !== 3) begin
      errors++;
      $display("FAIL w8_spacing: got %0d cycles, want 3", second_idx - first_idx);
    end
    repeat (3) @(posedge clk);
    #1;
    or8 = 1'b0;
  endtask

  initial begin
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    rst_n = 1'b1;
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
